led_scan_controller: RTL

//  Sequences the row/column LED driver. Steps the column index x over 0..N-1 with a

---
 rtl/led_scan_pkg.sv | 16 +
 rtl/led_scan_timer.sv | 41 ++++
 rtl/led_scan_controller.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/led_scan_pkg.sv
// Shared types and helpers for the LED row/column scan controller.
package led_scan_pkg;

   // Scan phases: idle (dark, parked at column 0), blank gap, lit dwell.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BLANK = 2'd1,
      S_ON    = 2'd2
   } scan_state_t;

   // Larger of two integers, used to size the shared phase counter.
   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/led_scan_timer.sv
// Load/decrement down-counter with a zero flag. One instance times both the
// blank and the dwell phase; it is reloaded at every phase change and parks
// at zero rather than wrapping.
module led_scan_timer #(
   parameter int CW = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] count,
   output logic          zero
);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   // Next count: a load wins over a decrement; decrement stops at zero.
   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != '0)) begin
         count_d = count_q - CW'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;
   assign zero  = (count_q == '0);

endmodule

// File: rtl/led_scan_controller.sv
// Column scan sequencer for the LED driver. Steps x across the grid with a
// dark gap before each lit column and swaps in a new frame only at the frame
// boundary so a displayed frame never tears.
//
// Handshake: a frame moves from cells_in to cells on every cycle where
// cells_valid && cells_ready are both high. cells_ready is a pure decode of
// the current state (high while idle, and in the final lit cycle of the last
// column); it never depends on cells_valid. The producer may hold cells_valid
// and cells_in for as long as it likes and must drop cells_valid after a
// handshake if it does not want the same frame taken again at the next
// boundary.
module led_scan_controller
   import led_scan_pkg::*;
#(
   parameter int N           = 8,
   parameter int DWELL_TICKS = 3,
   parameter int BLANK_TICKS = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic [N*N-1:0]           cells_in,
   input  logic                     cells_valid,
   output logic                     cells_ready,
   output logic                     ena,
   output logic [$clog2(N):0]       x,
   output logic [N*N-1:0]           cells,
   output logic                     frame_done,
   output scan_state_t              state_dbg
);

   localparam int XW = $clog2(N) + 1;
   localparam int CW = $clog2(max_of(DWELL_TICKS, BLANK_TICKS) + 1);
   localparam logic [XW-1:0] X_LAST    = XW'(N - 1);
   localparam logic [CW-1:0] BLANK_VAL = CW'(BLANK_TICKS - 1);
   localparam logic [CW-1:0] DWELL_VAL = CW'(DWELL_TICKS - 1);

   // Reject unsupported parameter values at elaboration time.
   if (N < 1 || N > 8) begin : g_bad_n
      $error("led_scan_controller: N must be in 1..8");
   end
   if (DWELL_TICKS < 1) begin : g_bad_dwell
      $error("led_scan_controller: DWELL_TICKS must be >= 1");
   end
   if (BLANK_TICKS < 1) begin : g_bad_blank
      $error("led_scan_controller: BLANK_TICKS must be >= 1");
   end

   scan_state_t     state_q, state_d;
   logic            ena_q, ena_d;
   logic [XW-1:0]   x_q, x_d;
   logic [N*N-1:0]  cells_q, cells_d;
   logic            frame_done_q, frame_done_d;

   logic            tmr_load;
   logic            tmr_dec;
   logic [CW-1:0]   tmr_val;
   logic [CW-1:0]   tmr_count;
   logic            tmr_zero;
   logic            at_boundary;
   logic            xfer;

   led_scan_timer #(
      .CW (CW)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .dec      (tmr_dec),
      .load_val (tmr_val),
      .count    (tmr_count),
      .zero     (tmr_zero)
   );

   // Frame boundary: the very last lit cycle of the last column.
   assign at_boundary = (state_q == S_ON) && tmr_zero && (x_q == X_LAST);
   assign cells_ready = (state_q == S_IDLE) || at_boundary;
   assign xfer        = cells_valid && cells_ready;

   // Next-state and registered-output logic. x only moves on transitions
   // that also take ena low, so a column change is never lit.
   always_comb begin
      state_d      = state_q;
      ena_d        = ena_q;
      x_d          = x_q;
      frame_done_d = 1'b0;
      tmr_load     = 1'b0;
      tmr_dec      = 1'b0;
      tmr_val      = '0;
      cells_d      = xfer ? cells_in : cells_q;

      case (state_q)
         S_IDLE: begin
            ena_d    = 1'b0;
            x_d      = '0;
            tmr_load = 1'b1;
            if (run) begin
               state_d = S_BLANK;
               tmr_val = BLANK_VAL;
            end
         end
         S_BLANK: begin
            ena_d   = 1'b0;
            tmr_dec = 1'b1;
            if (tmr_zero) begin
               state_d  = S_ON;
               ena_d    = 1'b1;
               tmr_load = 1'b1;
               tmr_val  = DWELL_VAL;
            end
         end
         S_ON: begin
            ena_d   = 1'b1;
            tmr_dec = 1'b1;
            if (tmr_zero) begin
               state_d  = S_BLANK;
               ena_d    = 1'b0;
               tmr_load = 1'b1;
               tmr_val  = BLANK_VAL;
               if (x_q == X_LAST) begin
                  x_d          = '0;
                  frame_done_d = 1'b1;
               end else begin
                  x_d = x_q + XW'(1);
               end
            end
         end
         default: begin
            state_d  = S_IDLE;
            ena_d    = 1'b0;
            x_d      = '0;
            tmr_load = 1'b1;
         end
      endcase

      // Stopping overrides everything: go dark, park at column 0, clear timer.
      if (!run) begin
         state_d      = S_IDLE;
         ena_d        = 1'b0;
         x_d          = '0;
         frame_done_d = 1'b0;
         tmr_load     = 1'b1;
         tmr_dec      = 1'b0;
         tmr_val      = '0;
      end
   end

   // State, column, enable, frame buffer and pulse registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         ena_q        <= 1'b0;
         x_q          <= '0;
         cells_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         ena_q        <= ena_d;
         x_q          <= x_d;
         cells_q      <= cells_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign ena        = ena_q;
   assign x          = x_q;
   assign cells      = cells_q;
   assign frame_done = frame_done_q;
   assign state_dbg  = state_q;

endmodule
